// File: rtl/disk_track_scheduler.sv
// Track buffer scheduler for two Disk II drives sharing one SD block port.
// Detects a requested-track mismatch per drive, writes back the held track
// when dirty, then reads the requested track block by block.
module disk_track_scheduler #(
    parameter int unsigned BLOCKS_PER_TRACK = 13,
    parameter int unsigned NUM_TRACKS       = 35
) (
    input  logic        CLK_14M,
    input  logic        RESET,
    input  logic [1:0]  DISK_MOUNTED,
    input  logic [5:0]  TRACK1,
    input  logic [5:0]  TRACK2,
    input  logic [1:0]  DIRTY,
    output logic [1:0]  DIRTY_CLR,
    output logic [1:0]  TRACK_BUSY,
    output logic [31:0] SD_LBA,
    output logic        SD_DRIVE,
    output logic [3:0]  SD_BLK,
    output logic        SD_RD,
    output logic        SD_WR,
    input  logic        SD_ACK
);
    localparam logic [5:0] TRK_INVALID = 6'h3F;
    localparam logic [5:0] TRK_MAX     = 6'(NUM_TRACKS - 1);
    localparam logic [3:0] BLK_LAST    = 4'(BLOCKS_PER_TRACK - 1);

    typedef enum logic [2:0] {
        IDLE, CHECK, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE
    } state_t;

    state_t          state_q, state_d;
    logic            cur_q, cur_d;
    logic [5:0]      tgt_q, tgt_d;
    logic [3:0]      blk_q, blk_d;
    logic            prio_q, prio_d;
    logic [1:0][5:0] loaded_q, loaded_d;
    logic [1:0]      mnt_q;
    logic            ack_q;

    logic [1:0]      dirty_clr_q, dclr_d;
    logic [1:0]      busy_q;
    logic [31:0]     sd_lba_q, lba_d;
    logic            sd_drive_q, sd_rd_q, sd_wr_q;
    logic [3:0]      sd_blk_q;

    logic [1:0][5:0] req_trk;
    logic [1:0]      need, mnt_rise;
    logic            sel, mnt_cur, ack_rise, ack_fall, active;

    assign DIRTY_CLR  = dirty_clr_q;
    assign TRACK_BUSY = busy_q;
    assign SD_LBA     = sd_lba_q;
    assign SD_DRIVE   = sd_drive_q;
    assign SD_BLK     = sd_blk_q;
    assign SD_RD      = sd_rd_q;
    assign SD_WR      = sd_wr_q;

    // Clamp requested tracks and flag drives whose buffer does not hold them
    always_comb begin
        req_trk[0] = (TRACK1 > TRK_MAX) ? TRK_MAX : TRACK1;
        req_trk[1] = (TRACK2 > TRK_MAX) ? TRK_MAX : TRACK2;
        need[0]    = DISK_MOUNTED[0] & (req_trk[0] != loaded_q[0]);
        need[1]    = DISK_MOUNTED[1] & (req_trk[1] != loaded_q[1]);
        mnt_rise   = DISK_MOUNTED & ~mnt_q;
        active     = (state_q != IDLE);
    end

    // Next-state logic for arbitration, write-back and load sequencing
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        tgt_d    = tgt_q;
        blk_d    = blk_q;
        prio_d   = prio_q;
        loaded_d = loaded_q;
        dclr_d   = '0;
        sel      = 1'b0;
        lba_d    = '0;
        mnt_cur  = DISK_MOUNTED[cur_q];
        ack_rise = SD_ACK & ~ack_q;
        ack_fall = ~SD_ACK & ack_q;

        unique case (state_q)
            IDLE: begin
                if (|need) begin
                    sel     = (&need) ? prio_q : need[1];
                    cur_d   = sel;
                    tgt_d   = req_trk[sel];
                    state_d = CHECK;
                end
            end
            CHECK: begin
                blk_d = '0;
                if (!mnt_cur) begin
                    loaded_d[cur_q] = TRK_INVALID;
                    state_d         = IDLE;
                end else if (DIRTY[cur_q] && (loaded_q[cur_q] != TRK_INVALID)) begin
                    state_d = WR_REQ;
                end else begin
                    state_d = RD_REQ;
                end
            end
            WR_REQ, RD_REQ: begin
                // An unmount withdraws the request at once unless an ack is
                // high; that handshake is drained through the WAIT state.
                if (!mnt_cur) begin
                    if (SD_ACK) begin
                        state_d = (state_q == WR_REQ) ? WR_WAIT : RD_WAIT;
                    end else begin
                        loaded_d[cur_q] = TRK_INVALID;
                        state_d         = IDLE;
                    end
                end else if (ack_rise) begin
                    state_d = (state_q == WR_REQ) ? WR_WAIT : RD_WAIT;
                end
            end
            WR_WAIT: begin
                if (ack_fall) begin
                    if (!mnt_cur) begin
                        loaded_d[cur_q] = TRK_INVALID;
                        state_d         = IDLE;
                    end else if (blk_q == BLK_LAST) begin
                        dclr_d[cur_q] = 1'b1;
                        blk_d         = '0;
                        state_d       = RD_REQ;
                    end else begin
                        blk_d   = blk_q + 4'd1;
                        state_d = WR_REQ;
                    end
                end
            end
            RD_WAIT: begin
                if (ack_fall) begin
                    if (!mnt_cur) begin
                        loaded_d[cur_q] = TRK_INVALID;
                        state_d         = IDLE;
                    end else if (blk_q == BLK_LAST) begin
                        state_d = DONE;
                    end else begin
                        blk_d   = blk_q + 4'd1;
                        state_d = RD_REQ;
                    end
                end
            end
            DONE: begin
                if (!mnt_cur) begin
                    loaded_d[cur_q] = TRK_INVALID;
                end else begin
                    loaded_d[cur_q] = tgt_q;
                    prio_d          = ~cur_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A fresh mount always forces a load of the first requested track
        if (mnt_rise[0]) loaded_d[0] = TRK_INVALID;
        if (mnt_rise[1]) loaded_d[1] = TRK_INVALID;

        unique case (state_d)
            WR_REQ, WR_WAIT: lba_d = 32'(loaded_q[cur_d]) * 32'(BLOCKS_PER_TRACK) + 32'(blk_d);
            RD_REQ, RD_WAIT: lba_d = 32'(tgt_d) * 32'(BLOCKS_PER_TRACK) + 32'(blk_d);
            default:         lba_d = '0;
        endcase
    end

    // State, bookkeeping and registered host-side outputs
    always_ff @(posedge CLK_14M or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            cur_q       <= 1'b0;
            tgt_q       <= '0;
            blk_q       <= '0;
            prio_q      <= 1'b0;
            loaded_q    <= {TRK_INVALID, TRK_INVALID};
            mnt_q       <= '0;
            ack_q       <= 1'b0;
            dirty_clr_q <= '0;
            busy_q      <= '0;
            sd_lba_q    <= '0;
            sd_drive_q  <= 1'b0;
            sd_blk_q    <= '0;
            sd_rd_q     <= 1'b0;
            sd_wr_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            tgt_q       <= tgt_d;
            blk_q       <= blk_d;
            prio_q      <= prio_d;
            loaded_q    <= loaded_d;
            mnt_q       <= DISK_MOUNTED;
            ack_q       <= SD_ACK;
            dirty_clr_q <= dclr_d;
            busy_q      <= {need[1] | (active & cur_q), need[0] | (active & ~cur_q)};
            sd_lba_q    <= lba_d;
            sd_drive_q  <= (state_d != IDLE) & cur_d;
            sd_blk_q    <= (state_d != IDLE) ? blk_d : '0;
            sd_rd_q     <= (state_d == RD_REQ);
            sd_wr_q     <= (state_d == WR_REQ);
        end
    end
endmodule

// File: tb/tb_disk_track_scheduler.sv
// Bench for disk_track_scheduler: a randomized-latency SD host logs every
// block request; a track-level model predicts the request sequence.
module tb_disk_track_scheduler;
    localparam int NBLK = 13;
    localparam int NTRK = 35;

    logic        CLK_14M = 1'b0;
    logic        RESET;
    logic [1:0]  DISK_MOUNTED;
    logic [5:0]  TRACK1, TRACK2;
    logic [1:0]  DIRTY;
    logic [1:0]  DIRTY_CLR, TRACK_BUSY;
    logic [31:0] SD_LBA;
    logic        SD_DRIVE, SD_RD, SD_WR, SD_ACK;
    logic [3:0]  SD_BLK;

    typedef struct packed {
        logic        wr;
        logic        drv;
        logic [31:0] lba;
        logic [3:0]  blk;
    } xfer_t;

    xfer_t      log_q[$];
    xfer_t      exp_q[$];
    int         tests = 0;
    int         fails = 0;
    int         hphase = 0;
    int         hcnt = 0;
    int         dclr_cycles [2];
    int         dclr_at = -1;
    int         busy01 = 0;
    logic       both_seen = 1'b0;
    logic [1:0] m_valid = 2'b00;
    logic [5:0] m_trk [2];
    int         m_dclr [2];

    disk_track_scheduler #(.BLOCKS_PER_TRACK(NBLK), .NUM_TRACKS(NTRK)) dut (
        .CLK_14M(CLK_14M), .RESET(RESET), .DISK_MOUNTED(DISK_MOUNTED),
        .TRACK1(TRACK1), .TRACK2(TRACK2), .DIRTY(DIRTY), .DIRTY_CLR(DIRTY_CLR),
        .TRACK_BUSY(TRACK_BUSY), .SD_LBA(SD_LBA), .SD_DRIVE(SD_DRIVE),
        .SD_BLK(SD_BLK), .SD_RD(SD_RD), .SD_WR(SD_WR), .SD_ACK(SD_ACK)
    );

    always #5 CLK_14M = ~CLK_14M;

    // SD host: logs each new request, acks after a random delay, holds a random time
    initial begin
        SD_ACK = 1'b0;
        dclr_cycles[0] = 0;
        dclr_cycles[1] = 0;
        forever begin
            @(posedge CLK_14M);
            #1;
            if (SD_RD && SD_WR) both_seen = 1'b1;
            if (DIRTY_CLR[0]) begin dclr_cycles[0]++; dclr_at = log_q.size(); end
            if (DIRTY_CLR[1]) begin dclr_cycles[1]++; dclr_at = log_q.size(); end
            if (RESET) begin
                SD_ACK = 1'b0;
                hphase = 0;
            end else begin
                case (hphase)
                    0: if (SD_RD || SD_WR) begin
                        log_q.push_back('{wr: SD_WR, drv: SD_DRIVE, lba: SD_LBA, blk: SD_BLK});
                        hcnt   = int'($urandom_range(1, 10));
                        hphase = 1;
                    end
                    1: begin
                        hcnt--;
                        if (hcnt == 0) begin
                            SD_ACK = 1'b1;
                            hcnt   = int'($urandom_range(2, 4));
                            hphase = 2;
                        end
                    end
                    default: begin
                        hcnt--;
                        if (hcnt == 0) begin
                            SD_ACK = 1'b0;
                            hphase = 0;
                        end
                    end
                endcase
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_blocks(input logic wr, input logic d, input logic [5:0] trk,
                               input int first, input int count);
        for (int i = first; i < first + count; i++)
            exp_q.push_back('{wr: wr, drv: d, lba: 32'(trk) * 32'(NBLK) + 32'(i), blk: 4'(i)});
    endtask

    // Track-level model: clamp, skip if already held, write back if dirty and valid, then load
    task automatic model_load(input logic d, input logic [5:0] req, input logic dirty);
        logic [5:0] t;
        t = (req >= 6'(NTRK)) ? 6'(NTRK - 1) : req;
        if (m_valid[d] && (m_trk[d] == t)) return;
        if (dirty && m_valid[d]) begin
            push_blocks(1'b1, d, m_trk[d], 0, NBLK);
            m_dclr[d]++;
        end
        push_blocks(1'b0, d, t, 0, NBLK);
        m_trk[d]   = t;
        m_valid[d] = 1'b1;
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_count"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            check($sformatf("%s_lba%0d", tag, i), log_q[i].lba, exp_q[i].lba);
            check($sformatf("%s_wr%0d", tag, i), 32'(log_q[i].wr), 32'(exp_q[i].wr));
            check($sformatf("%s_drv%0d", tag, i), 32'(log_q[i].drv), 32'(exp_q[i].drv));
            check($sformatf("%s_blk%0d", tag, i), 32'(log_q[i].blk), 32'(exp_q[i].blk));
        end
        check({tag, "_dclr0"}, 32'(dclr_cycles[0]), 32'(m_dclr[0]));
        check({tag, "_dclr1"}, 32'(dclr_cycles[1]), 32'(m_dclr[1]));
        log_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_quiet(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge CLK_14M);
            n++;
            if (TRACK_BUSY == 2'b01) busy01++;
        end while ((TRACK_BUSY != 2'b00 || hphase != 0 || SD_ACK) && n < 5000);
        check({tag, "_quiet_in_time"}, 32'(n < 5000), 32'd1);
    endtask

    task automatic wait_xfer(input string tag, input int cnt, input logic wr_low);
        int n;
        n = 0;
        do begin
            @(negedge CLK_14M);
            n++;
        end while (!(log_q.size() == cnt && SD_ACK && (!wr_low || !SD_WR)) && n < 5000);
        check({tag, "_reached"}, 32'(n < 5000), 32'd1);
    endtask

    initial begin
        m_dclr[0] = 0;
        m_dclr[1] = 0;
        RESET = 1'b1;
        DISK_MOUNTED = 2'b00;
        TRACK1 = 6'd0;
        TRACK2 = 6'd0;
        DIRTY = 2'b00;
        @(negedge CLK_14M);
        check("rst_lba", SD_LBA, 32'd0);
        check("rst_rdwr", 32'({SD_RD, SD_WR}), 32'd0);
        check("rst_busy", 32'(TRACK_BUSY), 32'd0);
        check("rst_dclr", 32'(DIRTY_CLR), 32'd0);
        check("rst_drvblk", 32'({SD_DRIVE, SD_BLK}), 32'd0);
        @(negedge CLK_14M);
        RESET = 1'b0;
        repeat (2) @(negedge CLK_14M);
        check("unmounted_idle", 32'({TRACK_BUSY, SD_RD, SD_WR}), 32'd0);

        // 1: mount drive 1 at track 0
        DISK_MOUNTED = 2'b01;
        model_load(1'b0, 6'd0, 1'b0);
        @(negedge CLK_14M);
        check("t1_busy", 32'(TRACK_BUSY), 32'b01);
        wait_quiet("t1");
        compare_log("t1");
        check("t1_idle_drvblk", 32'({SD_DRIVE, SD_BLK}), 32'd0);
        check("t1_idle_lba", SD_LBA, 32'd0);

        // 2: dirty write-back then load track 5
        DIRTY = 2'b01;
        TRACK1 = 6'd5;
        dclr_at = -1;
        model_load(1'b0, 6'd5, 1'b1);
        wait_quiet("t2");
        check("t2_dclr_after_writes", 32'(dclr_at), 32'd13);
        compare_log("t2");
        DIRTY = 2'b00;

        // 3: mount drive 2, then both tracks change together with priority on drive 1
        DISK_MOUNTED = 2'b11;
        model_load(1'b1, 6'd0, 1'b0);
        wait_quiet("t3a");
        compare_log("t3a");
        TRACK1 = 6'd3;
        TRACK2 = 6'd7;
        model_load(1'b0, 6'd3, 1'b0);
        model_load(1'b1, 6'd7, 1'b0);
        busy01 = 0;
        wait_quiet("t3b");
        compare_log("t3b");
        check("t3_busy1_held", 32'(busy01), 32'd0);

        // 4: out-of-range track clamps to the last track
        TRACK1 = 6'd40;
        model_load(1'b0, 6'd40, 1'b0);
        wait_quiet("t4");
        compare_log("t4");
        repeat (20) @(negedge CLK_14M);
        check("t4_busy_stays_clear", 32'(TRACK_BUSY), 32'd0);
        check("t4_no_reload", 32'(log_q.size()), 32'd0);

        // 5: unmount drive 1 during block 4 of a read, then remount
        TRACK1 = 6'd10;
        push_blocks(1'b0, 1'b0, 6'd10, 0, 5);
        wait_xfer("t5", 5, 1'b0);
        DISK_MOUNTED = 2'b10;
        m_valid[0] = 1'b0;
        wait_quiet("t5");
        repeat (30) @(negedge CLK_14M);
        check("t5_busy", 32'(TRACK_BUSY), 32'd0);
        compare_log("t5");
        DISK_MOUNTED = 2'b11;
        model_load(1'b0, 6'd10, 1'b0);
        wait_quiet("t5r");
        compare_log("t5r");

        // 6: reset while a write-back block is in flight
        DIRTY = 2'b01;
        TRACK1 = 6'd20;
        push_blocks(1'b1, 1'b0, 6'd10, 0, 3);
        wait_xfer("t6", 3, 1'b1);
        RESET = 1'b1;
        #1;
        check("t6_async_rdwr", 32'({SD_RD, SD_WR}), 32'd0);
        check("t6_async_busy", 32'(TRACK_BUSY), 32'd0);
        check("t6_async_lba", SD_LBA, 32'd0);
        compare_log("t6_pre");
        m_valid = 2'b00;
        repeat (3) @(negedge CLK_14M);
        RESET = 1'b0;
        model_load(1'b0, 6'd20, 1'b1);
        model_load(1'b1, 6'd7, 1'b0);
        wait_quiet("t6");
        compare_log("t6");
        DIRTY = 2'b00;

        // Random track requests on either drive
        for (int k = 0; k < 8; k++) begin
            logic       d;
            logic [5:0] t;
            logic       dt;
            d  = 1'($urandom_range(0, 1));
            t  = 6'($urandom_range(0, 63));
            dt = 1'($urandom_range(0, 1));
            if (d) TRACK2 = t; else TRACK1 = t;
            DIRTY = d ? {dt, 1'b0} : {1'b0, dt};
            model_load(d, t, dt);
            wait_quiet($sformatf("rnd%0d", k));
            compare_log($sformatf("rnd%0d", k));
            DIRTY = 2'b00;
        end

        check("rd_wr_exclusive", 32'(both_seen), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/disk_track_scheduler.md
Name: disk_track_scheduler

Overview:
- Shares one SD block interface between the two Disk II drive track buffers.
- Watches each drive's requested track (TRACK1/TRACK2) against the track currently held in that drive's buffer.
- On a mismatch it writes back the old track if dirty, then loads the new one as BLOCKS_PER_TRACK 512-byte blocks.
- Holds TRACK_BUSY for that drive until the buffer is valid. Sits between disk_ii and the SD/image host interface.

Parameters:
BLOCKS_PER_TRACK  13  512-byte blocks per track (13*512 = 6656 bytes, fits the 13-bit TRACK_ADDR space)
NUM_TRACKS  35  tracks per image; requested tracks >= NUM_TRACKS are clamped to NUM_TRACKS-1

Ports:
CLK_14M  in  1  system clock
RESET  in  1  asynchronous, active-high reset
DISK_MOUNTED  in  2  bit n = image present for drive n
TRACK1  in  6  drive 1 requested track
TRACK2  in  6  drive 2 requested track
DIRTY  in  2  bit n = drive n buffer modified since load
DIRTY_CLR  out  2  one-cycle pulse, bit n, when drive n write-back completes
TRACK_BUSY  out  2  bit n = drive n buffer not valid for requested track
SD_LBA  out  32  block address within the selected image
SD_DRIVE  out  1  image/buffer selected (0 = drive 1, 1 = drive 2)
SD_BLK  out  4  block index within track; buffer byte address = SD_BLK*512 + host offset
SD_RD  out  1  block read request
SD_WR  out  1  block write request
SD_ACK  in  1  host acknowledge; high while the block transfer is in progress

Behaviour:
- Reset (async) values:
  - All outputs 0.
  - loaded_trk[0..1] = 6'h3F (invalid).
  - Round-robin priority = drive 0.
  - State IDLE.
- req_trk[n] = min(TRACKn, NUM_TRACKS-1).
- need[n] = DISK_MOUNTED[n] & (req_trk[n] != loaded_trk[n]).
- TRACK_BUSY[n] is registered: need[n] | (operation active on n). It follows need with one cycle of latency.
- Rising edge of DISK_MOUNTED[n] sets loaded_trk[n] = 6'h3F. This forces a load of the first track.
- States:
  - IDLE:
    - If exactly one need[n] is set, service n.
    - If both are set, service the drive holding priority.
    - Latch cur = n and tgt = req_trk[n]; go to CHECK.
  - CHECK:
    - If DIRTY[cur] and loaded_trk[cur] != 6'h3F: blk = 0, go to WR_REQ.
    - Else: blk = 0, go to RD_REQ.
  - WR_REQ:
    - SD_WR = 1, SD_LBA = loaded_trk[cur]*BLOCKS_PER_TRACK + blk.
    - On SD_ACK rising: SD_WR = 0, go to WR_WAIT.
  - WR_WAIT:
    - On SD_ACK falling: if blk == BLOCKS_PER_TRACK-1, pulse DIRTY_CLR[cur], blk = 0, go to RD_REQ.
    - Else blk++ and return to WR_REQ.
  - RD_REQ:
    - SD_RD = 1, SD_LBA = tgt*BLOCKS_PER_TRACK + blk.
    - On SD_ACK rising: SD_RD = 0, go to RD_WAIT.
  - RD_WAIT:
    - On SD_ACK falling: if last block, go to DONE.
    - Else blk++ and return to RD_REQ.
  - DONE:
    - loaded_trk[cur] = tgt; priority = ~cur; go to IDLE. TRACK_BUSY[cur] clears the next cycle if req_trk still equals tgt.
    - If the request moved during the load, need stays set and a new load follows.
- SD_RD and SD_WR are never high together. Both are low in all states other than RD_REQ/WR_REQ.
- SD_DRIVE = cur and SD_BLK = blk during any operation. Both are 0 in IDLE.
- The target is latched at IDLE. Track changes during an operation do not alter SD_LBA mid-track.
- Unmount during an operation (DISK_MOUNTED[cur] falls):
  - The current block handshake is finished, waiting for SD_ACK to fall if it is high.
  - Then loaded_trk[cur] = 6'h3F; no DIRTY_CLR; go to IDLE.
  - No further requests are issued.
- If SD_ACK is already high on entry to a REQ state, the block waits for it to fall and then rise again. Only edges are counted.
- DIRTY is sampled only in CHECK.
- Reset mid-operation: immediate return to reset values. The host transfer is abandoned.

Test Plan:
1. Mount drive 1 (DISK_MOUNTED = 01), TRACK1 = 0, host acks each request after 10 cycles:
   - TRACK_BUSY = 01.
   - 13 reads with SD_LBA 0..12, SD_DRIVE = 0.
   - Then TRACK_BUSY = 00.
2. Drive 1 loaded at track 0, DIRTY = 01, TRACK1 -> 5:
   - 13 writes with LBA 0..12, then a DIRTY_CLR[0] pulse.
   - Then 13 reads with LBA 65..77.
3. Both mounted, TRACK1 = 3 and TRACK2 = 7 change on the same cycle, priority 0:
   - Drive 1 loads LBA 39..51 first.
   - Then drive 2 loads LBA 91..103 with SD_DRIVE = 1.
   - TRACK_BUSY[1] stays high throughout.
4. TRACK1 = 40 on a 35-track image:
   - Loads track 34, LBA 442..454.
   - TRACK_BUSY[0] clears while TRACK1 stays 40.
5. Unmount drive 1 during block 4 of a read:
   - No SD_RD after the SD_ACK falling edge.
   - TRACK_BUSY[0] = 0, and remount reloads the track.
6. Assert RESET during WR_WAIT:
   - SD_WR, SD_RD and TRACK_BUSY go to 0 asynchronously.
   - After release, with the drive still mounted, the load restarts from block 0 with no write-back.
